alu_pipe_param: RTL and testbench

//  Parametrised, pipelined successor of the 8-bit ALU: same MODE/CMD op set at WIDTH bits, valid/ready

---
 rtl/alu_pipe_param.sv | 232 +++++++++++++++++++++++
 tb/tb_alu_pipe_param.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_param.sv
// alu_pipe_param: two-stage valid/ready ALU (S1 operand capture, S2 registered RES + flags).
// Define ALU_MUL_EN to add the iterative shift-add multiplier (MODE=1, CMD=9) in S1.

module alu_pipe_param #(
  parameter int WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CE,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [WIDTH-1:0]     OPA,
  input  logic [WIDTH-1:0]     OPB,
  input  logic                 CIN,
  input  logic                 MODE,
  input  logic [3:0]           CMD,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [2*WIDTH-1:0]   RES,
  output logic                 COUT,
  output logic                 OFLOW,
  output logic                 G,
  output logic                 E,
  output logic                 L,
  output logic                 ERR
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH) + 1;
  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

  logic               s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               cin_q, cin_d, mode_q, mode_d;
  logic [3:0]         cmd_q, cmd_d;

  logic               out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic [5:0]         flags_q, flags_d;

  logic               s1_done, out_free, accept, advance, deliver;

  logic [WIDTH:0]     ext_a, ext_b, ext_cin, wide;
  logic [WIDTH-1:0]   nar;
  logic [2*WIDTH-1:0] rot, mul_res, alu_res;
  logic [SHW-1:0]     sh;
  logic               f_cout, f_oflow, f_g, f_e, f_l, f_err;

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] mul_acc_q, mul_acc_d, mul_mcand_q, mul_mcand_d;
  logic [WIDTH-1:0]   mul_mplier_q, mul_mplier_d;
  logic [CW-1:0]      mul_cnt_q, mul_cnt_d;
  logic               s1_is_mul;

  assign s1_is_mul = mode_q & (cmd_q == 4'd9);
  assign s1_done   = ~s1_is_mul | (mul_cnt_q == CW'(WIDTH));
`else
  assign s1_done   = 1'b1;
`endif

  assign out_free = ~out_valid_q | OUT_READY;
  assign IN_READY = CE & ~RST & (~s1_valid_q | (s1_done & out_free));
  assign accept   = IN_VALID & IN_READY;
  assign advance  = CE & s1_valid_q & s1_done & out_free;
  assign deliver  = CE & out_valid_q & OUT_READY;

  always_comb begin
    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    cin_d      = cin_q;
    mode_d     = mode_q;
    cmd_d      = cmd_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      a_d        = OPA;
      b_d        = OPB;
      cin_d      = CIN;
      mode_d     = MODE;
      cmd_d      = CMD;
    end else if (advance) begin
      s1_valid_d = 1'b0;
    end
  end

`ifdef ALU_MUL_EN
  // First partial product is formed at accept so the whole multiply spans WIDTH cycles in S1.
  always_comb begin
    mul_acc_d    = mul_acc_q;
    mul_mcand_d  = mul_mcand_q;
    mul_mplier_d = mul_mplier_q;
    mul_cnt_d    = mul_cnt_q;
    if (accept) begin
      mul_acc_d    = OPB[0] ? {{WIDTH{1'b0}}, OPA} : '0;
      mul_mcand_d  = {{(WIDTH-1){1'b0}}, OPA, 1'b0};
      mul_mplier_d = OPB >> 1;
      mul_cnt_d    = CW'(1);
    end else if (CE && s1_valid_q && s1_is_mul && !s1_done) begin
      if (mul_mplier_q[0]) mul_acc_d = mul_acc_q + mul_mcand_q;
      mul_mcand_d  = mul_mcand_q << 1;
      mul_mplier_d = mul_mplier_q >> 1;
      mul_cnt_d    = mul_cnt_q + CW'(1);
    end
  end
`endif

  assign ext_a   = {1'b0, a_q};
  assign ext_b   = {1'b0, b_q};
  assign ext_cin = {{WIDTH{1'b0}}, cin_q};
  assign sh      = b_q[SHW-1:0];

  always_comb begin
    wide    = '0;
    nar     = '0;
    rot     = '0;
    mul_res = '0;
    f_cout  = 1'b0;
    f_oflow = 1'b0;
    f_g     = 1'b0;
    f_e     = 1'b0;
    f_l     = 1'b0;
    f_err   = 1'b0;
    if (mode_q) begin
      case (cmd_q)
        4'd0: begin wide = ext_a + ext_b;           f_cout  = wide[WIDTH]; end
        4'd1: begin wide = ext_a - ext_b;           f_oflow = (ext_a < ext_b); end
        4'd2: begin wide = ext_a + ext_b + ext_cin; f_cout  = wide[WIDTH]; end
        4'd3: begin wide = ext_a - ext_b - ext_cin; f_oflow = (ext_a < (ext_b + ext_cin)); end
        4'd4: wide = ext_a + ONE;
        4'd5: wide = ext_a - ONE;
        4'd6: wide = ext_b + ONE;
        4'd7: wide = ext_b - ONE;
        4'd8: begin
          f_g = (a_q > b_q);
          f_e = (a_q == b_q);
          f_l = (a_q < b_q);
        end
`ifdef ALU_MUL_EN
        4'd9: begin mul_res = mul_acc_q; f_cout = |mul_acc_q[2*WIDTH-1:WIDTH]; end
`endif
        default: f_err = 1'b1;
      endcase
    end else begin
      case (cmd_q)
        4'd0:  nar = a_q & b_q;
        4'd1:  nar = ~(a_q & b_q);
        4'd2:  nar = a_q | b_q;
        4'd3:  nar = ~(a_q | b_q);
        4'd4:  nar = a_q ^ b_q;
        4'd5:  nar = ~(a_q ^ b_q);
        4'd6:  nar = ~a_q;
        4'd7:  nar = ~b_q;
        4'd8:  nar = a_q >> 1;
        4'd9:  nar = a_q << 1;
        4'd10: nar = b_q >> 1;
        4'd11: nar = b_q << 1;
        // Rotates shift a doubled copy of A; the wrapped bits land in the kept half.
        4'd12: begin
          rot   = {a_q, a_q} << sh;
          nar   = rot[2*WIDTH-1:WIDTH];
          f_err = |b_q[WIDTH-1:SHW];
        end
        4'd13: begin
          rot   = {a_q, a_q} >> sh;
          nar   = rot[WIDTH-1:0];
          f_err = |b_q[WIDTH-1:SHW];
        end
        default: f_err = 1'b1;
      endcase
    end
    alu_res = {{(WIDTH-1){1'b0}}, wide} | {{WIDTH{1'b0}}, nar} | mul_res;
  end

  // Result and flags only change when a new beat moves in, so an undelivered beat stays stable.
  always_comb begin
    out_valid_d = out_valid_q;
    res_d       = res_q;
    flags_d     = flags_q;
    if (advance) begin
      out_valid_d = 1'b1;
      res_d       = alu_res;
      flags_d     = {f_cout, f_oflow, f_g, f_e, f_l, f_err};
    end else if (deliver) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      mode_q      <= 1'b0;
      cmd_q       <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      flags_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      mode_q      <= mode_d;
      cmd_q       <= cmd_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      flags_q     <= flags_d;
    end
  end

`ifdef ALU_MUL_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mul_acc_q    <= '0;
      mul_mcand_q  <= '0;
      mul_mplier_q <= '0;
      mul_cnt_q    <= '0;
    end else begin
      mul_acc_q    <= mul_acc_d;
      mul_mcand_q  <= mul_mcand_d;
      mul_mplier_q <= mul_mplier_d;
      mul_cnt_q    <= mul_cnt_d;
    end
  end
`endif

  assign OUT_VALID = out_valid_q;
  assign RES       = res_q;
  assign {COUT, OFLOW, G, E, L, ERR} = flags_q;

endmodule

// File: tb/tb_alu_pipe_param.sv
// tb_alu_pipe_param: scoreboard bench for alu_pipe_param (WIDTH=8); expected beats come from
// an arithmetic reference model, a monitor pops and compares on every delivered beat.

module tb_alu_pipe_param;

  localparam int W = 8;

  logic           CLK, RST, CE, IN_VALID, IN_READY, CIN, MODE, OUT_VALID, OUT_READY;
  logic [W-1:0]   OPA, OPB;
  logic [3:0]     CMD;
  logic [2*W-1:0] RES;
  logic           COUT, OFLOW, G, E, L, ERR;

  alu_pipe_param #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OPA(OPA), .OPB(OPB), .CIN(CIN), .MODE(MODE), .CMD(CMD),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .RES(RES),
    .COUT(COUT), .OFLOW(OFLOW), .G(G), .E(E), .L(L), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Beat layout: {RES, COUT, OFLOW, G, E, L, ERR}
  logic [2*W+5:0] exp_q[$];
  int errors = 0, checks = 0;
  int pushed = 0, flushed = 0, delivered = 0;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [2*W+5:0] model(input logic [W-1:0] a, b, input logic cin, mode,
                                           input logic [3:0] cmd);
    longint unsigned ua = a, ub = b, uc = cin, r = 0;
    longint unsigned m = (64'd1 << W) - 1, m1 = (64'd1 << (W + 1)) - 1;
    logic co = 0, ov = 0, g = 0, e = 0, l = 0, er = 0;
    int s = int'(ub % W);
    if (mode) begin
      case (cmd)
        0: begin r = ua + ub; co = (r > m); end
        1: begin r = (ua - ub) & m1; ov = (ua < ub); end
        2: begin r = ua + ub + uc; co = (r > m); end
        3: begin r = (ua - ub - uc) & m1; ov = (ua < ub + uc); end
        4: r = (ua + 1) & m1;
        5: r = (ua - 1) & m1;
        6: r = (ub + 1) & m1;
        7: r = (ub - 1) & m1;
        8: begin g = (ua > ub); e = (ua == ub); l = (ua < ub); end
`ifdef ALU_MUL_EN
        9: begin r = ua * ub; co = (r > m); end
`endif
        default: er = 1;
      endcase
    end else begin
      case (cmd)
        0: r = ua & ub;
        1: r = ~(ua & ub) & m;
        2: r = ua | ub;
        3: r = ~(ua | ub) & m;
        4: r = ua ^ ub;
        5: r = ~(ua ^ ub) & m;
        6: r = ~ua & m;
        7: r = ~ub & m;
        8: r = ua >> 1;
        9: r = (ua << 1) & m;
        10: r = ub >> 1;
        11: r = (ub << 1) & m;
        12: begin r = ((ua << s) | (ua >> (W - s))) & m; er = (ub >= W); end
        13: begin r = ((ua >> s) | (ua << (W - s))) & m; er = (ub >= W); end
        default: er = 1;
      endcase
    end
    return {r[2*W-1:0], co, ov, g, e, l, er};
  endfunction

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic applyStimulus(input logic [W-1:0] a, b, input logic cin, mode,
                               input logic [3:0] cmd, output int waited);
    waited = 0;
    IN_VALID = 1'b1; OPA = a; OPB = b; CIN = cin; MODE = mode; CMD = cmd;
    forever begin
      @(negedge CLK);
      if (CE && IN_READY) begin
        exp_q.push_back(model(a, b, cin, mode, cmd));
        pushed++;
        @(posedge CLK); #1;
        break;
      end
      waited++;
      if (waited > 300) begin
        checkOutput("accept_timeout", 64'(waited), 64'd0);
        @(posedge CLK); #1;
        break;
      end
      @(posedge CLK); #1;
    end
    IN_VALID = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge CLK);
      n++;
    end
    #1;
    checkOutput(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: compares delivered beats and checks that an undelivered beat stays put.
  logic           pend = 1'b0;
  logic [2*W+5:0] held;
  always @(negedge CLK) begin
    logic [2*W+5:0] cur;
    cur = {RES, COUT, OFLOW, G, E, L, ERR};
    if (RST) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        checkOutput("hold_valid", 64'(OUT_VALID), 64'd1);
        if (OUT_VALID) checkOutput("hold_beat", 64'(cur), 64'(held));
      end
      if (CE && OUT_VALID && OUT_READY) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_beat", 64'(cur), 64'h0);
          if (cur == '0) checkOutput("unexpected_beat_valid", 64'd1, 64'd0);
        end else begin
          checkOutput("beat", 64'(cur), 64'(exp_q.pop_front()));
        end
        delivered++;
        pend = 1'b0;
      end else if (OUT_VALID) begin
        pend = 1'b1;
        held = cur;
      end else begin
        pend = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int w1, w2, w3;
    logic rand_done;
    RST = 1'b1; CE = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1;
    OPA = '0; OPB = '0; CIN = 1'b0; MODE = 1'b0; CMD = '0;
    #2;
    checkOutput("rst_out_valid", 64'(OUT_VALID), 64'd0);
    checkOutput("rst_res", 64'(RES), 64'd0);
    checkOutput("rst_flags", 64'({COUT, OFLOW, G, E, L, ERR}), 64'd0);
    checkOutput("rst_in_ready", 64'(IN_READY), 64'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;

    // Latency of a single-cycle op from an empty pipe
    applyStimulus(8'h3C, 8'h0F, 1'b0, 1'b0, 4'd4, w1);
    @(negedge CLK);
    checkOutput("lat_early", 64'(OUT_VALID), 64'd0);
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("lat_single", 64'(OUT_VALID), 64'd1);
    @(posedge CLK); #1;
    waitDrain("drain_lat");

    // Back-to-back ADD / SUB_CIN must be accepted on consecutive cycles
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b1, 4'd0, w1);
    applyStimulus(8'h10, 8'h20, 1'b1, 1'b1, 4'd3, w2);
    checkOutput("b2b_wait", 64'(w2), 64'd0);

    applyStimulus(8'h5A, 8'h5A, 1'b0, 1'b1, 4'd8, w1);
    applyStimulus(8'h80, 8'h7F, 1'b0, 1'b1, 4'd8, w1);
    applyStimulus(8'h00, 8'h01, 1'b0, 1'b1, 4'd8, w1);
    applyStimulus(8'h81, 8'h03, 1'b0, 1'b0, 4'd12, w1);
    applyStimulus(8'h81, 8'h13, 1'b0, 1'b0, 4'd13, w1);
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b1, 4'd5, w1);
    applyStimulus(8'hFF, 8'h00, 1'b0, 1'b1, 4'd4, w1);
    applyStimulus(8'hA5, 8'h0F, 1'b0, 1'b0, 4'd14, w1);
    applyStimulus(8'hA5, 8'h0F, 1'b0, 1'b1, 4'd15, w1);
    applyStimulus(8'hFF, 8'hFF, 1'b0, 1'b1, 4'd9, w1);
    waitDrain("drain_directed");

`ifdef ALU_MUL_EN
    applyStimulus(8'hFF, 8'hFF, 1'b0, 1'b1, 4'd9, w1);
    for (int i = 0; i < W; i++) begin
      @(negedge CLK);
      checkOutput("lat_mul_wait", 64'(OUT_VALID), 64'd0);
      if (i < W - 1) checkOutput("mul_in_ready", 64'(IN_READY), 64'd0);
      @(posedge CLK);
    end
    @(negedge CLK);
    checkOutput("lat_mul", 64'(OUT_VALID), 64'd1);
    @(posedge CLK); #1;
    waitDrain("drain_mul");
`endif

    // Back-pressure: three beats while the consumer stalls for five cycles
    OUT_READY = 1'b0;
    fork
      begin
        applyStimulus(8'h11, 8'h22, 1'b0, 1'b1, 4'd0, w1);
        applyStimulus(8'h33, 8'h44, 1'b1, 1'b1, 4'd2, w2);
        applyStimulus(8'hF0, 8'h0F, 1'b0, 1'b0, 4'd2, w3);
      end
      begin
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checkOutput("bp_in_ready", 64'(IN_READY), 64'd0);
        repeat (2) @(posedge CLK);
        #1 OUT_READY = 1'b1;
      end
    join
    waitDrain("drain_bp");

    // Reset mid-stream with a full pipe
    OUT_READY = 1'b0;
    applyStimulus(8'h12, 8'h34, 1'b0, 1'b1, 4'd0, w1);
    applyStimulus(8'h56, 8'h78, 1'b0, 1'b0, 4'd4, w1);
    @(posedge CLK); #3;
    RST = 1'b1;
    #1;
    checkOutput("mid_rst_out_valid", 64'(OUT_VALID), 64'd0);
    checkOutput("mid_rst_res", 64'(RES), 64'd0);
    checkOutput("mid_rst_flags", 64'({COUT, OFLOW, G, E, L, ERR}), 64'd0);
    checkOutput("mid_rst_in_ready", 64'(IN_READY), 64'd0);
    flushed += exp_q.size();
    exp_q.delete();
    @(posedge CLK); #3;
    RST = 1'b0;
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    applyStimulus(8'h77, 8'h01, 1'b1, 1'b1, 4'd3, w1);
    applyStimulus(8'h01, 8'h00, 1'b0, 1'b0, 4'd9, w1);
    waitDrain("drain_resume");

    // Randomized stream with random gaps, clock-enable and consumer stalls
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          int wr;
          logic [W-1:0] ra, rb;
          if ($urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 3)) begin @(posedge CLK); #1; end
          ra = ($urandom_range(0, 4) == 0) ? W'($urandom_range(0, 1) * 255) : W'($urandom_range(0, 255));
          rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, W - 1)) : W'($urandom_range(0, 255));
          applyStimulus(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        4'($urandom_range(0, 15)), wr);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge CLK); #1;
          OUT_READY = ($urandom_range(0, 3) != 0);
          CE        = ($urandom_range(0, 7) != 0);
        end
        CE = 1'b1;
        OUT_READY = 1'b1;
      end
    join
    waitDrain("drain_random");
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("beat_count", 64'(delivered), 64'(pushed - flushed));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
